shift_exec_unit: RTL and testbench
==================================

SHIFT_EXEC_UNIT -- requirements
Module: shift_exec_unit

Interface
REQ-001 Parameter W, default 4, operand width in bits; result width is 2*W; shift-amount width SW = $clog2(W).
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low, synchronous deassert at the clk boundary.
REQ-004 in_valid  input  1  upstream presents a valid command.
REQ-005 in_ready  output  1  unit can accept a command.
REQ-006 op  input  3  opcode: 0 LSL a, 1 ASL a, 2 LSR b, 3 ASR b, 4 CON {b,a}, 5 REP {2{a}}, 6-7 illegal.
REQ-007 a  input  W  signed operand A.
REQ-008 b  input  W  signed operand B.
REQ-009 shamt  input  SW  shift amount, 0..W-1; ignored for ops 4-7.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 result  output  2*W  operation result.
REQ-013 err  output  1  qualified by out_valid; high when the executed op was illegal.

Function
REQ-014 Accept: command captured at the rising edge where in_valid && in_ready; in_ready = (state == IDLE), purely from state.
REQ-015 FSM states: IDLE, SHIFT, DONE; no other reachable states.
REQ-016 IDLE -> SHIFT on accept of op 0-3 with shamt != 0; load the working register with the selected operand and cnt = shamt.
REQ-017 IDLE -> DONE on accept of op 0-3 with shamt == 0, or of op 4-7; result computed in the accept cycle.
REQ-018 SHIFT: each cycle shifts the working register by exactly one bit and decrements cnt; on the cycle cnt == 1 the final value is loaded into result and state moves to DONE.
REQ-019 LSL/ASL: shift left, fill with zeros; identical results; result[2W-1:W] = 0.
REQ-020 LSR: shift right, fill with zeros; result[2W-1:W] = 0.
REQ-021 ASR: shift right, fill with the sign bit of b; result[2W-1:W] is replicated from the final MSB (sign-extended).
REQ-022 CON: result = {b, a}; REP: result = {a, a}; err = 0 for ops 0-5.
REQ-023 Illegal op (6, 7): result = 0, err = 1, latency 1 cycle.
REQ-024 Latency, from accept edge to first cycle of out_valid: max(shamt, 1) for ops 0-3, 1 for ops 4-7.
REQ-025 DONE: out_valid = 1; result and err held stable while out_ready = 0; DONE -> IDLE on the edge where out_ready = 1.
REQ-026 No accept in DONE or SHIFT; no same-cycle pop-and-accept; maximum throughput is one command per latency + 2 cycles.
REQ-027 Inputs a, b, op and shamt are not sampled after the accept edge; changes during SHIFT/DONE do not affect the result.

Reset
REQ-028 While rst_n = 0: state = IDLE, cnt = 0, working register = 0, result = 0, err = 0, out_valid = 0, in_ready = 0.
REQ-029 Reset asserted mid-SHIFT or mid-DONE aborts the command immediately; no result is emitted after release.
REQ-030 First accept is possible on the first rising edge after rst_n deasserts.

Structure
REQ-031 Shared package shift_concat_pkg holds the opcode enum (OP_LSL..OP_REP), the FSM state enum, and the default W.
REQ-032 One sub-module, shift_step: combinational single-bit shift of a W-bit value with direction and fill-bit inputs; instantiated once in the SHIFT datapath.
REQ-033 All outputs are driven from registers or state decode; there is no combinational path from inputs to outputs.

Verification (W = 4)
REQ-034 LSL a=4'b0101, shamt=2 -> result 8'h04, err 0, out_valid 2 cycles after accept.
REQ-035 ASR b=4'b1000, shamt=2 -> 8'hFE; LSR b=4'b1000, shamt=3 -> 8'h01 after 3 cycles; shamt=0 -> 8'h08 after 1 cycle.
REQ-036 CON a=4'h3, b=4'hA -> 8'hA3; REP a=4'h5 -> 8'h55; op=6 -> 8'h00 with err=1; each op has 1-cycle latency.
REQ-037 Backpressure: out_ready held low for 5 cycles in DONE -> result stable, in_ready 0, in_valid ignored; single pop on the first out_ready high.
REQ-038 rst_n pulsed low during SHIFT (LSL, shamt=3) -> outputs reach reset values asynchronously; no out_valid after release; next command executes correctly.

Source files
------------

// File: rtl/shift_concat_pkg.sv
// Shared types for the shift/concat execution unit:
// opcode enum, FSM state enum and default operand width.
package shift_concat_pkg;

    localparam int W_DEF = 4;

    // Codes 6 and 7 are deliberately left unnamed: they decode as illegal.
    typedef enum logic [2:0] {
        OP_LSL = 3'd0,
        OP_ASL = 3'd1,
        OP_LSR = 3'd2,
        OP_ASR = 3'd3,
        OP_CON = 3'd4,
        OP_REP = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Single-bit shifter for a W-bit value.
// Ports: i_val value, i_left direction (1 = left), i_fill incoming bit, o_val result.
module shift_step #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_val,
    input  logic         i_left,
    input  logic         i_fill,
    output logic [W-1:0] o_val
);

    assign o_val = i_left ? {i_val[W-2:0], i_fill}
                          : {i_fill, i_val[W-1:1]};

endmodule

// File: rtl/shift_exec_unit.sv
// Multi-cycle shift / concatenate execution unit with valid/ready handshakes.
// Ports: clk, rst_n; in_valid/in_ready/op/a/b/shamt command; out_valid/out_ready/result/err response.
module shift_exec_unit
    import shift_concat_pkg::*;
#(
    parameter  int W  = W_DEF,
    localparam int SW = $clog2(W)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic [SW-1:0]   shamt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0]  result,
    output logic            err
);

    state_e           r_state, w_state_nxt;
    logic [SW-1:0]    r_cnt, w_cnt_nxt;
    logic [W-1:0]     r_work, w_work_nxt;
    logic             r_left, w_left_nxt;
    logic             r_asr, w_asr_nxt;
    logic [2*W-1:0]   r_result, w_result_nxt;
    logic             r_err, w_err_nxt;
    logic [W-1:0]     w_step;
    logic [W-1:0]     w_operand;
    logic             w_fill;

    function automatic logic [2*W-1:0] f_ext(input logic [W-1:0] v, input logic sx);
        return sx ? {{W{v[W-1]}}, v} : {{W{1'b0}}, v};
    endfunction

    // Right shifts (ops 2,3) work on b, left shifts on a.
    assign w_operand = op[1] ? b : a;

    // ASR keeps re-injecting the original sign bit, which never changes.
    assign w_fill = r_asr & r_work[W-1];

    shift_step #(.W(W)) u_step (
        .i_val  (r_work),
        .i_left (r_left),
        .i_fill (w_fill),
        .o_val  (w_step)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_work_nxt   = r_work;
        w_left_nxt   = r_left;
        w_asr_nxt    = r_asr;
        w_result_nxt = r_result;
        w_err_nxt    = r_err;
        unique case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (!op[2] && shamt != '0) begin
                        w_state_nxt = ST_SHIFT;
                        w_work_nxt  = w_operand;
                        w_cnt_nxt   = shamt;
                        w_left_nxt  = !op[1];
                        w_asr_nxt   = (op == 3'd3);
                        w_err_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = ST_DONE;
                        w_err_nxt   = 1'b0;
                        case (op_e'(op))
                            OP_LSL,
                            OP_ASL,
                            OP_LSR:  w_result_nxt = f_ext(w_operand, 1'b0);
                            OP_ASR:  w_result_nxt = f_ext(w_operand, 1'b1);
                            OP_CON:  w_result_nxt = {b, a};
                            OP_REP:  w_result_nxt = {a, a};
                            default: begin
                                w_result_nxt = '0;
                                w_err_nxt    = 1'b1;
                            end
                        endcase
                    end
                end
            end
            ST_SHIFT: begin
                w_work_nxt = w_step;
                w_cnt_nxt  = r_cnt - SW'(1);
                if (r_cnt == SW'(1)) begin
                    w_result_nxt = f_ext(w_step, r_asr);
                    w_state_nxt  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_work   <= '0;
            r_left   <= 1'b0;
            r_asr    <= 1'b0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_work   <= w_work_nxt;
            r_left   <= w_left_nxt;
            r_asr    <= w_asr_nxt;
            r_result <= w_result_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // The state flop sits at IDLE during reset; masking with rst_n keeps
    // in_ready low until reset is released.
    assign in_ready  = (r_state == ST_IDLE) && rst_n;
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign err       = r_err;

endmodule

// File: tb/tb_shift_exec_unit.sv
// Directed self-checking bench for shift_exec_unit (W = 4).
// Each test task drives its scenario and checks outputs inline.
module tb_shift_exec_unit;

    localparam int W  = 4;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [SW-1:0] shamt;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] result;
    logic          err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    shift_exec_unit #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err)
    );

    // lat = rising edges after the accept edge before out_valid is seen
    // (0 means the result is registered straight into DONE by the accept edge).
    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] sh;
        logic [7:0] res;
        int         lat;
    } vec_t;

    vec_t shv [10] = '{
        '{3'd0, 4'b0101, 4'hF, 2'd2, 8'h04, 2},
        '{3'd1, 4'b0011, 4'h0, 2'd1, 8'h06, 1},
        '{3'd3, 4'hF, 4'b1000, 2'd2, 8'hFE, 2},
        '{3'd2, 4'hF, 4'b1000, 2'd3, 8'h01, 3},
        '{3'd2, 4'h0, 4'b1000, 2'd0, 8'h08, 0},
        '{3'd3, 4'h0, 4'b0110, 2'd1, 8'h03, 1},
        '{3'd3, 4'h0, 4'b1000, 2'd0, 8'hF8, 0},
        '{3'd0, 4'b1001, 4'h0, 2'd3, 8'h08, 3},
        '{3'd3, 4'h0, 4'b1011, 2'd3, 8'hFF, 3},
        '{3'd1, 4'b1111, 4'h0, 2'd0, 8'h0F, 0}
    };

    task automatic issue(input logic [2:0] t_op, input logic [3:0] t_a,
                         input logic [3:0] t_b, input logic [1:0] t_sh);
        @(negedge clk);
        op       = t_op;
        a        = t_a;
        b        = t_b;
        shamt    = t_sh;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble operands: the unit must not look at them any more.
        op    = 3'd6;
        a     = ~t_a;
        b     = ~t_b;
        shamt = ~t_sh;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic pop();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 3'd0;
        a         = '0;
        b         = '0;
        shamt     = '0;
        #1;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_out_valid: got %b expected 0", out_valid);
        end
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL rst_in_ready: got %b expected 0", in_ready);
        end
        tests++;
        if (result !== 8'h00) begin
            fails++;
            $display("FAIL rst_result: got %h expected 00", result);
        end
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL rst_err: got %b expected 0", err);
        end
        // Present CON before release so it is taken on the very first edge.
        in_valid = 1'b1;
        op       = 3'd4;
        a        = 4'h3;
        b        = 4'hA;
        #11;
        rst_n = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rel_in_ready: got %b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || result !== 8'hA3) begin
            fails++;
            $display("FAIL first_accept: got v=%b r=%h expected v=1 r=a3",
                     out_valid, result);
        end
        pop();
    endtask

    task automatic test_shift();
        int n;
        for (int i = 0; i < 10; i++) begin
            issue(shv[i].op, shv[i].a, shv[i].b, shv[i].sh);
            wait_valid(n);
            tests++;
            if (n !== shv[i].lat) begin
                fails++;
                $display("FAIL shift_lat[%0d]: got %0d expected %0d",
                         i, n, shv[i].lat);
            end
            tests++;
            if (result !== shv[i].res || err !== 1'b0) begin
                fails++;
                $display("FAIL shift_res[%0d]: got %h err=%b expected %h err=0",
                         i, result, err, shv[i].res);
            end
            pop();
            tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL shift_pop[%0d]: got v=%b rdy=%b expected v=0 rdy=1",
                         i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_single_cycle();
        logic [2:0] ops [4];
        logic [3:0] as  [4];
        logic [3:0] bs  [4];
        logic [7:0] exp_r [4];
        logic       exp_e [4];
        int n;
        ops = '{3'd4, 3'd5, 3'd6, 3'd7};
        as  = '{4'h3, 4'h5, 4'hC, 4'h7};
        bs  = '{4'hA, 4'h9, 4'hD, 4'h1};
        exp_r = '{8'hA3, 8'h55, 8'h00, 8'h00};
        exp_e = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], 2'd3);
            wait_valid(n);
            tests++;
            if (n !== 0) begin
                fails++;
                $display("FAIL imm_lat[%0d]: got %0d expected 0", i, n);
            end
            tests++;
            if (result !== exp_r[i] || err !== exp_e[i]) begin
                fails++;
                $display("FAIL imm_res[%0d]: got %h err=%b expected %h err=%b",
                         i, result, err, exp_r[i], exp_e[i]);
            end
            pop();
        end
    endtask

    task automatic test_backpressure();
        int n;
        issue(3'd2, 4'h0, 4'hC, 2'd1);
        wait_valid(n);
        @(negedge clk);
        in_valid = 1'b1;
        op       = 3'd4;
        a        = 4'hF;
        b        = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (out_valid !== 1'b1 || result !== 8'h06 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got v=%b r=%h rdy=%b expected v=1 r=06 rdy=0",
                         i, out_valid, result, in_ready);
            end
        end
        pop();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_pop: got v=%b rdy=%b expected v=0 rdy=1",
                     out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || result !== 8'hFF) begin
            fails++;
            $display("FAIL bp_next: got v=%b r=%h expected v=1 r=ff",
                     out_valid, result);
        end
        pop();
    endtask

    task automatic test_reset_mid_shift();
        int n;
        int seen;
        issue(3'd0, 4'h1, 4'h0, 2'd3);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_pre: got v=%b expected 0", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || result !== 8'h00 || err !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL mid_rst: got v=%b r=%h e=%b rdy=%b expected 0 00 0 0",
                     out_valid, result, err, in_ready);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL mid_ghost: got %0d valid cycles expected 0", seen);
        end
        issue(3'd0, 4'h1, 4'h0, 2'd3);
        wait_valid(n);
        tests++;
        if (n !== 3 || result !== 8'h08) begin
            fails++;
            $display("FAIL mid_after: got lat=%0d r=%h expected lat=3 r=08",
                     n, result);
        end
        pop();
    endtask

    task automatic test_back_to_back();
        int n;
        issue(3'd5, 4'hA, 4'h0, 2'd0);
        wait_valid(n);
        tests++;
        if (n !== 0 || result !== 8'hAA) begin
            fails++;
            $display("FAIL b2b_first: got lat=%0d r=%h expected lat=0 r=aa",
                     n, result);
        end
        pop();
        issue(3'd3, 4'h0, 4'h9, 2'd1);
        wait_valid(n);
        tests++;
        if (n !== 1 || result !== 8'hFC || err !== 1'b0) begin
            fails++;
            $display("FAIL b2b_second: got lat=%0d r=%h e=%b expected lat=1 r=fc e=0",
                     n, result, err);
        end
        pop();
    endtask

    initial begin
        test_reset();
        test_shift();
        test_single_cycle();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
